perf_run_monitor: RTL and testbench



---
 rtl/perf_pkg.sv | 24 ++
 rtl/perf_run_monitor_sat_counter.sv | 46 ++++
 rtl/perf_run_monitor.sv | 164 ++++++++++++++++
 tb/tb_perf_run_monitor.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/perf_pkg.sv
// ---------------------------------------------------------------------------
// perf_pkg
// Shared definitions for the run/performance monitor:
//   state_e    - run-control FSM encoding (IDLE, RUN, DONE, TIMEOUT)
//   SEL_CYCLES - read-select code of the elapsed-cycle counter; event
//                channel i is read with select i+1.
// ---------------------------------------------------------------------------
package perf_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        DONE    = 2'd2,
        TIMEOUT = 2'd3
    } state_e;

    localparam int SEL_CYCLES = 0;

    // True when the monitor is actively accumulating counts.
    function automatic logic is_counting(input state_e s);
        return (s == RUN);
    endfunction

endpackage

// File: rtl/perf_run_monitor_sat_counter.sv
// ---------------------------------------------------------------------------
// sat_counter
// Saturating up-counter with a sticky overflow flag.
//   clk        : clock, rising edge
//   reset      : synchronous active-high reset (count and flag to 0)
//   clear      : synchronous clear, same effect as reset
//   en         : counting window is open this cycle
//   inc        : increment request (qualified by en)
//   count      : current counter value
//   ovf_sticky : set when an increment arrives while count is all-ones;
//                held until reset or clear
// ---------------------------------------------------------------------------
module sat_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             en,
    input  logic             inc,
    output logic [CNT_W-1:0] count,
    output logic             ovf_sticky
);

    logic [CNT_W-1:0] count_reg;
    logic             ovf_reg;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count_reg <= '0;
            ovf_reg   <= 1'b0;
        end else if (en && inc) begin
            // At all-ones the value holds instead of wrapping; the lost
            // increment is recorded in the sticky flag.
            if (&count_reg) begin
                ovf_reg <= 1'b1;
            end else begin
                count_reg <= count_reg + CNT_W'(1);
            end
        end
    end

    assign count      = count_reg;
    assign ovf_sticky = ovf_reg;

endmodule

// File: rtl/perf_run_monitor.sv
// ---------------------------------------------------------------------------
// perf_run_monitor
// Counts elapsed cycles and NUM_EVT event channels between a start pulse and
// a completion match on the monitored datapath output, with an optional
// cycle-limit timeout. Results freeze at completion/timeout and are read
// through a registered select port.
//
// Ports:
//   CLK          : clock, rising edge
//   reset        : synchronous active-high reset
//   start        : one-cycle pulse; zero counters/flags and (re)start a run
//   clr          : return to IDLE, zero counters/flags
//   match_en     : enable completion matching
//   match_value  : expected final datapath value
//   out_valid    : datapath output valid this cycle
//   out_data     : datapath output value
//   evt          : per-channel event strobes (one count per high cycle)
//   sel          : read select; 0 = cycles, i = event channel i-1
//   rd_data      : selected counter, registered (1-cycle latency)
//   ovf          : sticky saturation flags; bit 0 cycles, bit i event i-1
//   busy/done/timeout : decoded from the registered FSM state
// ---------------------------------------------------------------------------
module perf_run_monitor
    import perf_pkg::*;
#(
    parameter  int WIDTH       = 16,
    parameter  int CNT_W       = 32,
    parameter  int NUM_EVT     = 4,
    parameter  int TIMEOUT_CYC = 100000,
    localparam int SEL_W       = $clog2(NUM_EVT + 1)
) (
    input  logic               CLK,
    input  logic               reset,
    input  logic               start,
    input  logic               clr,
    input  logic               match_en,
    input  logic [WIDTH-1:0]   match_value,
    input  logic               out_valid,
    input  logic [WIDTH-1:0]   out_data,
    input  logic [NUM_EVT-1:0] evt,
    input  logic [SEL_W-1:0]   sel,
    output logic [CNT_W-1:0]   rd_data,
    output logic [NUM_EVT:0]   ovf,
    output logic               busy,
    output logic               done,
    output logic               timeout
);

    state_e state_reg;
    state_e state_next;

    // Counter bank: index 0 is the cycle counter, index i is event i-1.
    logic [CNT_W-1:0] cnt [NUM_EVT+1];
    logic [NUM_EVT:0] ovf_bits;
    logic [NUM_EVT:0] inc_vec;

    logic             clear_cnt;
    logic             cnt_en;
    logic             match_hit;
    logic             timeout_hit;
    logic [CNT_W-1:0] cycles_cur;
    logic [CNT_W-1:0] cycles_post;

    logic [CNT_W-1:0] rd_data_reg;
    logic [CNT_W-1:0] rd_data_next;

    // -----------------------------------------------------------------------
    // Counter control
    // -----------------------------------------------------------------------
    // start and clr both zero the bank; the start cycle itself is never
    // counted because counting is only enabled when neither is present.
    assign clear_cnt = clr | start;
    assign cnt_en    = is_counting(state_reg) && !clear_cnt;

    // The cycle counter advances every RUN cycle; events follow their strobes.
    assign inc_vec = {evt, 1'b1};

    generate
        for (genvar gi = 0; gi <= NUM_EVT; gi++) begin : g_cnt
            sat_counter #(
                .CNT_W (CNT_W)
            ) u_cnt (
                .clk        (CLK),
                .reset      (reset),
                .clear      (clear_cnt),
                .en         (cnt_en),
                .inc        (inc_vec[gi]),
                .count      (cnt[gi]),
                .ovf_sticky (ovf_bits[gi])
            );
        end
    endgenerate

    // -----------------------------------------------------------------------
    // Completion and timeout detection
    // -----------------------------------------------------------------------
    assign match_hit = match_en && out_valid && (out_data == match_value);

    // Value the cycle counter will hold after this edge (saturating), so the
    // timeout fires on the same edge that makes the count equal the limit.
    assign cycles_cur  = cnt[SEL_CYCLES];
    assign cycles_post = (&cycles_cur) ? cycles_cur : cycles_cur + CNT_W'(1);

    // Compared at 64 bits so a limit wider than the counter never aliases
    // onto a truncated value.
    assign timeout_hit = (TIMEOUT_CYC != 0) &&
                         (64'(cycles_post) == 64'(TIMEOUT_CYC));

    // -----------------------------------------------------------------------
    // Run-control FSM; order of tests gives clr > start > match > timeout.
    // -----------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        if (clr) begin
            state_next = IDLE;
        end else if (start) begin
            state_next = RUN;
        end else if (state_reg == RUN) begin
            if (match_hit) begin
                state_next = DONE;
            end else if (timeout_hit) begin
                state_next = TIMEOUT;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // -----------------------------------------------------------------------
    // Registered read port; selects beyond the bank read as zero.
    // -----------------------------------------------------------------------
    always_comb begin
        rd_data_next = '0;
        for (int i = 0; i <= NUM_EVT; i++) begin
            if (sel == SEL_W'(i)) begin
                rd_data_next = cnt[i];
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            rd_data_reg <= '0;
        end else begin
            rd_data_reg <= rd_data_next;
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign rd_data = rd_data_reg;
    assign ovf     = ovf_bits;
    assign busy    = (state_reg == RUN);
    assign done    = (state_reg == DONE);
    assign timeout = (state_reg == TIMEOUT);

endmodule

// File: tb/tb_perf_run_monitor.sv
// ---------------------------------------------------------------------------
// tb_perf_run_monitor
// Two monitor instances share one stimulus stream:
//   dut_a : CNT_W=32, TIMEOUT_CYC=50
//   dut_b : CNT_W=4,  TIMEOUT_CYC=0 (saturation corner)
// A behavioural model (counts in plain integers, run mode as a number) is
// stepped on every edge and compared with both instances; directed tables
// and sequences add hand-computed expectations.
// ---------------------------------------------------------------------------
module tb_perf_run_monitor;

    localparam int NE = 4;

    localparam int M_IDLE = 0;
    localparam int M_RUN  = 1;
    localparam int M_DONE = 2;
    localparam int M_TO   = 3;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        clr = 1'b0;
    logic        match_en = 1'b0;
    logic [15:0] match_value = '0;
    logic        out_valid = 1'b0;
    logic [15:0] out_data = '0;
    logic [3:0]  evt = '0;
    logic [2:0]  sel = '0;

    logic [31:0] rd_a;
    logic [4:0]  ovf_a;
    logic        busy_a, done_a, timeout_a;
    logic [3:0]  rd_b;
    logic [4:0]  ovf_b;
    logic        busy_b, done_b, timeout_b;

    int vectors = 0;
    int miscompares = 0;

    // Reference model state, one slot per instance
    longint unsigned m_cnt [2][NE+1];
    bit              m_ovf [2][NE+1];
    int              m_mode [2];
    longint unsigned m_rd [2];

    always #5 clk = ~clk;

    perf_run_monitor #(
        .WIDTH(16), .CNT_W(32), .NUM_EVT(NE), .TIMEOUT_CYC(50)
    ) dut_a (
        .CLK(clk), .reset(reset), .start(start), .clr(clr),
        .match_en(match_en), .match_value(match_value),
        .out_valid(out_valid), .out_data(out_data), .evt(evt), .sel(sel),
        .rd_data(rd_a), .ovf(ovf_a), .busy(busy_a), .done(done_a),
        .timeout(timeout_a)
    );

    perf_run_monitor #(
        .WIDTH(16), .CNT_W(4), .NUM_EVT(NE), .TIMEOUT_CYC(0)
    ) dut_b (
        .CLK(clk), .reset(reset), .start(start), .clr(clr),
        .match_en(match_en), .match_value(match_value),
        .out_valid(out_valid), .out_data(out_data), .evt(evt), .sel(sel),
        .rd_data(rd_b), .ovf(ovf_b), .busy(busy_b), .done(done_b),
        .timeout(timeout_b)
    );

    task automatic chk(input string name, input longint unsigned act,
                       input longint unsigned exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock of the reference model, using the inputs about to be sampled.
    task automatic model_step(input int k);
        longint unsigned cmax;
        longint unsigned limit;
        bit              hit;
        cmax  = (k == 0) ? 64'hFFFF_FFFF : 64'd15;
        limit = (k == 0) ? 64'd50 : 64'd0;
        if (reset) begin
            m_mode[k] = M_IDLE;
            m_rd[k]   = 0;
            for (int j = 0; j <= NE; j++) begin
                m_cnt[k][j] = 0;
                m_ovf[k][j] = 0;
            end
            return;
        end
        m_rd[k] = (int'(sel) <= NE) ? m_cnt[k][sel] : 0;
        if (clr || start) begin
            m_mode[k] = clr ? M_IDLE : M_RUN;
            for (int j = 0; j <= NE; j++) begin
                m_cnt[k][j] = 0;
                m_ovf[k][j] = 0;
            end
        end else if (m_mode[k] == M_RUN) begin
            for (int j = 0; j <= NE; j++) begin
                if (j == 0 || evt[j-1]) begin
                    if (m_cnt[k][j] == cmax) m_ovf[k][j] = 1;
                    else m_cnt[k][j] = m_cnt[k][j] + 1;
                end
            end
            hit = match_en && out_valid && (out_data == match_value);
            if (hit) m_mode[k] = M_DONE;
            else if (limit != 0 && m_cnt[k][0] == limit) m_mode[k] = M_TO;
        end
    endtask

    function automatic logic [4:0] m_ovf_vec(input int k);
        logic [4:0] v;
        for (int j = 0; j <= NE; j++) v[j] = m_ovf[k][j];
        return v;
    endfunction

    // Advance one clock and compare both instances against the model.
    task automatic tick();
        model_step(0);
        model_step(1);
        @(posedge clk);
        #1;
        chk("busy_a",    busy_a,    m_mode[0] == M_RUN);
        chk("done_a",    done_a,    m_mode[0] == M_DONE);
        chk("timeout_a", timeout_a, m_mode[0] == M_TO);
        chk("rd_a",      rd_a,      m_rd[0]);
        chk("ovf_a",     ovf_a,     m_ovf_vec(0));
        chk("busy_b",    busy_b,    m_mode[1] == M_RUN);
        chk("done_b",    done_b,    m_mode[1] == M_DONE);
        chk("timeout_b", timeout_b, m_mode[1] == M_TO);
        chk("rd_b",      rd_b,      m_rd[1]);
        chk("ovf_b",     ovf_b,     m_ovf_vec(1));
    endtask

    typedef struct {
        logic        start;
        logic        clr;
        logic        ov;
        logic [15:0] od;
        logic [3:0]  ev;
        logic [2:0]  sel;
        logic        b;
        logic        d;
        logic        t;
        logic [31:0] rd;
    } vec_t;

    vec_t tbl [13];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // start clr ov od ev sel | busy done to rd
        tbl[0]  = '{1'b1, 1'b0, 1'b0, 16'd0,  4'h0, 3'd0, 1'b1, 1'b0, 1'b0, 32'd0};
        tbl[1]  = '{1'b0, 1'b0, 1'b0, 16'd0,  4'h1, 3'd1, 1'b1, 1'b0, 1'b0, 32'd0};
        tbl[2]  = '{1'b0, 1'b0, 1'b0, 16'd0,  4'h1, 3'd0, 1'b1, 1'b0, 1'b0, 32'd1};
        tbl[3]  = '{1'b0, 1'b0, 1'b1, 16'd13, 4'h3, 3'd1, 1'b0, 1'b1, 1'b0, 32'd2};
        tbl[4]  = '{1'b0, 1'b0, 1'b0, 16'd0,  4'hF, 3'd0, 1'b0, 1'b1, 1'b0, 32'd3};
        tbl[5]  = '{1'b0, 1'b0, 1'b0, 16'd0,  4'h0, 3'd2, 1'b0, 1'b1, 1'b0, 32'd1};
        tbl[6]  = '{1'b0, 1'b0, 1'b0, 16'd0,  4'h0, 3'd5, 1'b0, 1'b1, 1'b0, 32'd0};
        tbl[7]  = '{1'b0, 1'b1, 1'b0, 16'd0,  4'h0, 3'd1, 1'b0, 1'b0, 1'b0, 32'd3};
        tbl[8]  = '{1'b0, 1'b0, 1'b1, 16'd13, 4'hF, 3'd0, 1'b0, 1'b0, 1'b0, 32'd0};
        tbl[9]  = '{1'b0, 1'b0, 1'b0, 16'd0,  4'hF, 3'd1, 1'b0, 1'b0, 1'b0, 32'd0};
        tbl[10] = '{1'b1, 1'b0, 1'b1, 16'd13, 4'h0, 3'd0, 1'b1, 1'b0, 1'b0, 32'd0};
        tbl[11] = '{1'b0, 1'b0, 1'b1, 16'd13, 4'h0, 3'd0, 1'b0, 1'b1, 1'b0, 32'd0};
        tbl[12] = '{1'b0, 1'b0, 1'b0, 16'd0,  4'h0, 3'd0, 1'b0, 1'b1, 1'b0, 32'd1};

        // ---- reset state ----
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        chk("reset_busy", busy_a, 0);
        chk("reset_done", done_a, 0);
        chk("reset_timeout", timeout_a, 0);
        chk("reset_rd", rd_a, 0);
        chk("reset_ovf", ovf_a, 0);

        // ---- table: short run, freeze, clr, start-cycle match ----
        match_en    = 1'b1;
        match_value = 16'd13;
        for (int i = 0; i < 13; i++) begin
            start = tbl[i].start; clr = tbl[i].clr;
            out_valid = tbl[i].ov; out_data = tbl[i].od;
            evt = tbl[i].ev; sel = tbl[i].sel;
            tick();
            $display("row %0d: busy=%0b done=%0b timeout=%0b rd=%0d", i,
                     busy_a, done_a, timeout_a, rd_a);
            chk("tbl_busy", busy_a, tbl[i].b);
            chk("tbl_done", done_a, tbl[i].d);
            chk("tbl_timeout", timeout_a, tbl[i].t);
            chk("tbl_rd", rd_a, tbl[i].rd);
        end
        start = 0; clr = 0; out_valid = 0; out_data = 0; evt = 0;

        // ---- 40-cycle run, evt[0] for 25 cycles, match 11 on cycle 40 ----
        reset = 1'b1; tick(); reset = 1'b0;
        match_value = 16'd11;
        start = 1'b1; tick(); start = 1'b0;
        for (int i = 1; i <= 40; i++) begin
            evt       = (i <= 25) ? 4'h1 : 4'h0;
            out_valid = (i == 40);
            out_data  = (i == 40) ? 16'd11 : 16'd0;
            tick();
        end
        evt = 0; out_valid = 0; out_data = 0;
        chk("run40_done", done_a, 1);
        chk("run40_busy", busy_a, 0);
        // select sweep including out-of-range codes
        for (int s = 0; s <= 7; s++) begin
            sel = 3'(s);
            tick();
            $display("sweep sel=%0d rd=%0d", s, rd_a);
            chk("sweep_rd", rd_a, (s == 0) ? 40 : (s == 1) ? 25 : 0);
        end

        // ---- timeout after 50 cycles, frozen afterwards ----
        match_en = 1'b0;
        evt = 4'hF;
        start = 1'b1; tick(); start = 1'b0;
        repeat (49) tick();
        chk("to_before", timeout_a, 0);
        tick();
        chk("to_hit", timeout_a, 1);
        repeat (10) tick();
        sel = 3'd0; tick();
        chk("to_cycles", rd_a, 50);
        sel = 3'd1; tick();
        chk("to_evt0", rd_a, 50);
        chk("to_still", timeout_a, 1);
        evt = 0;

        // ---- match and timeout on the same cycle: DONE wins ----
        match_en = 1'b1; match_value = 16'd77;
        start = 1'b1; tick(); start = 1'b0;
        repeat (49) tick();
        out_valid = 1'b1; out_data = 16'd77;
        tick();
        out_valid = 1'b0; out_data = 0;
        chk("tie_done", done_a, 1);
        chk("tie_timeout", timeout_a, 0);

        // ---- 4-bit saturation on event 1 (dut_b) ----
        match_en = 1'b0;
        start = 1'b1; tick(); start = 1'b0;
        evt = 4'b0010;
        repeat (20) tick();
        evt = 0;
        sel = 3'd2; tick();
        chk("sat_evt1", rd_b, 15);
        chk("sat_ovf2", ovf_b[2], 1);
        start = 1'b1; tick(); start = 1'b0;
        chk("sat_ovf_clr", ovf_b, 0);
        tick();
        chk("sat_evt1_clr", rd_b, 0);

        // ---- reset mid-run ----
        start = 1'b1; tick(); start = 1'b0;
        repeat (6) begin evt = 4'($urandom); tick(); end
        reset = 1'b1; tick(); reset = 1'b0;
        evt = 0;
        chk("midrst_busy", busy_a, 0);
        chk("midrst_done", done_a, 0);
        for (int s = 0; s <= NE + 1; s++) begin
            sel = 3'(s);
            tick();
            chk("midrst_rd", rd_a, 0);
        end

        // ---- randomized traffic against the model ----
        match_value = 16'd2;
        for (int i = 0; i < 3000; i++) begin
            reset     = ($urandom_range(199) == 0);
            clr       = ($urandom_range(59) == 0);
            start     = ($urandom_range(29) == 0);
            match_en  = ($urandom_range(4) != 0);
            out_valid = ($urandom_range(7) == 0);
            out_data  = 16'($urandom_range(3));
            evt       = 4'($urandom);
            sel       = 3'($urandom);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
